// File: rtl/photocell_frontend.sv
// Photocell front end: per-channel synchroniser, debouncer and passage-qualifying FSM
// that produces single-cycle customer events and sticky stuck-beam flags.

module photocell_channel #(
    parameter int unsigned DEB       = 4,
    parameter int unsigned MIN_BLOCK = 8,
    parameter int unsigned STUCK     = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    input  logic fault_clr,
    output logic pulse,
    output logic stuck
);

    localparam int unsigned DEB_W = $clog2(DEB) + 1;
    localparam int unsigned DUR_W = $clog2(STUCK) + 1;

    typedef enum logic [1:0] {
        ST_CLEAR   = 2'd0,
        ST_BLOCKED = 2'd1,
        ST_STUCK   = 2'd2
    } state_t;

    logic [1:0]       sync_q;
    logic [DEB_W-1:0] deb_cnt_q;
    logic             deb_lvl_q;

    state_t           state_q, state_n;
    logic [DUR_W-1:0] dur_q, dur_n;
    logic             pulse_n;
    logic             stuck_set;
    logic             stuck_n;

    // Two-flop synchroniser for the asynchronous beam input
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], raw};
        end
    end

    // Debounced level flips only after DEB consecutive disagreeing samples
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_cnt_q <= '0;
            deb_lvl_q <= 1'b0;
        end else if (sync_q[1] == deb_lvl_q) begin
            deb_cnt_q <= '0;
        end else if (deb_cnt_q == DEB_W'(DEB - 1)) begin
            deb_lvl_q <= ~deb_lvl_q;
            deb_cnt_q <= '0;
        end else begin
            deb_cnt_q <= deb_cnt_q + DEB_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_CLEAR;
            dur_q   <= '0;
            pulse   <= 1'b0;
            stuck   <= 1'b0;
        end else begin
            state_q <= state_n;
            dur_q   <= dur_n;
            pulse   <= pulse_n;
            stuck   <= stuck_n;
        end
    end

    // Passage qualification; the blocked duration equals debounced-blocked cycles
    always_comb begin
        state_n   = state_q;
        dur_n     = dur_q;
        pulse_n   = 1'b0;
        stuck_set = 1'b0;
        unique case (state_q)
            ST_CLEAR: begin
                if (deb_lvl_q) begin
                    state_n = ST_BLOCKED;
                    dur_n   = DUR_W'(1);
                end
            end
            ST_BLOCKED: begin
                if (!deb_lvl_q) begin
                    state_n = ST_CLEAR;
                    pulse_n = (dur_q >= DUR_W'(MIN_BLOCK));
                end else if (dur_q == DUR_W'(STUCK - 1)) begin
                    state_n   = ST_STUCK;
                    dur_n     = dur_q + DUR_W'(1);
                    stuck_set = 1'b1;
                end else begin
                    dur_n = dur_q + DUR_W'(1);
                end
            end
            ST_STUCK: begin
                if (!deb_lvl_q) begin
                    state_n = ST_CLEAR;
                end
            end
            default: begin
                state_n = ST_CLEAR;
            end
        endcase
        // A new stuck condition takes priority over a simultaneous clear
        stuck_n = stuck_set | (stuck & ~fault_clr);
    end

endmodule

module photocell_frontend #(
    parameter int unsigned DEB       = 4,
    parameter int unsigned MIN_BLOCK = 8,
    parameter int unsigned STUCK     = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pc_start_raw,
    input  logic pc_end_raw,
    input  logic fault_clr,
    output logic int_start,
    output logic int_end,
    output logic stuck_start,
    output logic stuck_end
);

    photocell_channel #(
        .DEB       (DEB),
        .MIN_BLOCK (MIN_BLOCK),
        .STUCK     (STUCK)
    ) u_start (
        .clk       (clk),
        .reset_n   (reset_n),
        .raw       (pc_start_raw),
        .fault_clr (fault_clr),
        .pulse     (int_start),
        .stuck     (stuck_start)
    );

    photocell_channel #(
        .DEB       (DEB),
        .MIN_BLOCK (MIN_BLOCK),
        .STUCK     (STUCK)
    ) u_end (
        .clk       (clk),
        .reset_n   (reset_n),
        .raw       (pc_end_raw),
        .fault_clr (fault_clr),
        .pulse     (int_end),
        .stuck     (stuck_end)
    );

endmodule

// File: tb/tb_photocell_frontend.sv
// Directed bench for photocell_frontend with DEB=4, MIN_BLOCK=8, STUCK=64.

module tb_photocell_frontend;

    logic clk;
    logic reset_n;
    logic pc_start_raw;
    logic pc_end_raw;
    logic fault_clr;
    logic int_start;
    logic int_end;
    logic stuck_start;
    logic stuck_end;

    int checks;
    int errors;
    int cyc;
    int n_start;
    int n_end;
    int n_both;
    int last_start_cyc;
    int last_end_cyc;
    int k;
    int r;

    photocell_frontend #(
        .DEB       (4),
        .MIN_BLOCK (8),
        .STUCK     (64)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pc_start_raw (pc_start_raw),
        .pc_end_raw   (pc_end_raw),
        .fault_clr    (fault_clr),
        .int_start    (int_start),
        .int_end      (int_end),
        .stuck_start  (stuck_start),
        .stuck_end    (stuck_end)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock and tally output pulses sampled just after the edge
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (int_start) begin
            n_start++;
            last_start_cyc = cyc;
        end
        if (int_end) begin
            n_end++;
            last_end_cyc = cyc;
        end
        if (int_start && int_end) n_both++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clr_counts();
        n_start        = 0;
        n_end          = 0;
        n_both         = 0;
        last_start_cyc = -1;
        last_end_cyc   = -1;
    endtask

    // Hold the start beam for a number of raw cycles, then let it settle
    task automatic start_block(input int len);
        clr_counts();
        pc_start_raw = 1'b1;
        steps(len);
        pc_start_raw = 1'b0;
        steps(20);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        cyc          = 0;
        reset_n      = 1'b0;
        pc_start_raw = 1'b0;
        pc_end_raw   = 1'b0;
        fault_clr    = 1'b0;
        clr_counts();

        // Reset with inputs toggling
        for (int i = 0; i < 4; i++) begin
            #5;
            pc_start_raw = ~pc_start_raw;
            pc_end_raw   = ~pc_end_raw;
        end
        step();
        pc_start_raw = ~pc_start_raw;
        step();
        check("rst_int_start", int'(int_start), 0);
        check("rst_int_end", int'(int_end), 0);
        check("rst_stuck_start", int'(stuck_start), 0);
        check("rst_stuck_end", int'(stuck_end), 0);
        pc_start_raw = 1'b0;
        pc_end_raw   = 1'b0;
        reset_n      = 1'b1;
        clr_counts();
        steps(20);
        check("idle_pulses", n_start + n_end, 0);
        check("idle_stuck", int'(stuck_start) + int'(stuck_end), 0);

        // Single passage on the end beam
        clr_counts();
        pc_end_raw = 1'b1;
        steps(12);
        pc_end_raw = 1'b0;
        r = cyc + 1;
        steps(20);
        check("single_end_count", n_end, 1);
        check("single_end_latency", last_end_cyc - r, 6);
        check("single_start_quiet", n_start, 0);

        // Glitch and short-block filtering; debounced length equals raw length
        start_block(3);
        check("glitch3_no_pulse", n_start, 0);
        start_block(7);
        check("short7_no_pulse", n_start, 0);
        start_block(8);
        check("min8_pulse", n_start, 1);
        check("min8_end_quiet", n_end, 0);

        // Simultaneous passages
        clr_counts();
        pc_start_raw = 1'b1;
        pc_end_raw   = 1'b1;
        steps(12);
        pc_start_raw = 1'b0;
        pc_end_raw   = 1'b0;
        steps(20);
        check("simul_start", n_start, 1);
        check("simul_end", n_end, 1);
        check("simul_same_cycle", n_both, 1);

        // Stuck end beam; fault_clr coincident with the set edge must lose
        clr_counts();
        pc_end_raw = 1'b1;
        k = cyc + 1;
        while (cyc < k + 68) step();
        check("stuck_before", int'(stuck_end), 0);
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        check("stuck_set_wins", int'(stuck_end), 1);
        while (cyc < k + 79) step();
        pc_end_raw = 1'b0;
        steps(20);
        check("stuck_no_pulse", n_end, 0);
        check("stuck_sticky", int'(stuck_end), 1);
        check("stuck_other_chan", int'(stuck_start), 0);
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        check("stuck_cleared", int'(stuck_end), 0);
        clr_counts();
        pc_end_raw = 1'b1;
        steps(12);
        pc_end_raw = 1'b0;
        steps(20);
        check("after_clear_pulse", n_end, 1);

        // Reset in the middle of a block
        clr_counts();
        pc_end_raw = 1'b1;
        steps(5);
        reset_n = 1'b0;
        #1;
        check("midrst_int_end", int'(int_end), 0);
        step();
        reset_n = 1'b1;
        check("midrst_no_pulse", n_end, 0);
        steps(12);
        pc_end_raw = 1'b0;
        steps(20);
        check("midrst_one_pulse", n_end, 1);
        check("midrst_start_quiet", n_start, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
